// File: rtl/sa_pkg.sv
// ----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the spatial-array result path: the drain FSM state
// type and the default word/tile sizes used by the sa_cell column.
// ----------------------------------------------------------------------------
package sa_pkg;

   // One result word leaving an sa_cell (FP16).
   localparam int SA_DATA_WIDTH   = 16;

   // Largest result tile a column can stream out in one go.
   localparam int SA_MAX_TILE_LEN = 256;

   // Result drain controller states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } drain_state_t;

endpackage

// File: rtl/sa_sync_fifo.sv
// ----------------------------------------------------------------------------
// sa_sync_fifo
// Single-clock show-ahead FIFO. The head entry is visible on dout whenever the
// FIFO is not empty; a pop advances to the next entry on the following edge.
// A push while full is accepted only when a pop happens in the same cycle.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   push/din  write request and data (ignored when full without a pop)
//   pop       read request (ignored when empty)
//   dout      head entry, zero while empty
//   full      occupancy equals DEPTH
//   empty     occupancy equals zero
//   count     registered occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module sa_sync_fifo #(
   parameter  int WIDTH = 17,
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push && (!full || do_pop);
   assign count   = count_q;
   // Gate the head so stale storage never shows up while empty.
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage array carries no reset; only valid entries are ever visible.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sa_result_drain.sv
// ----------------------------------------------------------------------------
// sa_result_drain
// Captures the data_out stream leaving the last sa_cell of a column, counts
// beats into a tile of programmable length, buffers them and presents them
// to the host on a valid/ready stream with a last marker. The cell cannot be
// stalled, so a beat arriving to a full FIFO is dropped and flagged.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   start          one-cycle pulse starting a tile (ignored while busy)
//   tile_len       words in the tile, sampled on an accepted start
//   data_in        result word from the cell
//   data_in_valid  qualifies data_in
//   m_data/m_last  FIFO head word and its end-of-tile marker
//   m_valid        FIFO not empty
//   m_ready        host accepts the head word
//   busy           a tile is being collected or drained
//   done           one-cycle pulse once the tile has fully left the block
//   overflow       sticky: a word of the current tile was dropped
//   fifo_count     current FIFO occupancy
// ----------------------------------------------------------------------------
module sa_result_drain
   import sa_pkg::*;
#(
   parameter  int DATA_WIDTH   = SA_DATA_WIDTH,
   parameter  int FIFO_DEPTH   = 8,
   parameter  int MAX_TILE_LEN = SA_MAX_TILE_LEN,
   localparam int LEN_W        = $clog2(MAX_TILE_LEN + 1),
   localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      tile_len,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_in_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [CNT_W-1:0]      fifo_count
);

   drain_state_t          state;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      word_cnt;
   logic [LEN_W-1:0]      clamped_len;
   logic                  overflow_q;
   logic                  beat;
   logic                  is_last;
   logic                  pop;
   logic                  dropped;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH:0]   fifo_dout;

   assign clamped_len = (tile_len > LEN_W'(MAX_TILE_LEN)) ? LEN_W'(MAX_TILE_LEN)
                                                          : tile_len;

   // Only beats seen while collecting belong to the tile.
   assign beat    = (state == COLLECT) && data_in_valid;
   assign is_last = (word_cnt == len_q - LEN_W'(1));
   assign pop     = m_valid && m_ready;
   assign dropped = beat && fifo_full && !pop;

   // The stored word carries its end-of-tile marker in the top bit.
   sa_sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (beat),
      .din   ({is_last, data_in}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign m_data   = fifo_dout[DATA_WIDTH-1:0];
   assign m_last   = fifo_dout[DATA_WIDTH];
   assign m_valid  = !fifo_empty;
   assign overflow = overflow_q;
   assign busy     = (state != IDLE);
   // Decoded from registers only: high for the single DRAIN cycle in which
   // the FIFO is empty, which is also the cycle the FSM leaves DRAIN.
   assign done     = (state == DRAIN) && fifo_empty;

   // Tile controller: latches the length, counts every beat (dropped or not)
   // so the tile always terminates, and waits for the FIFO to empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         len_q      <= '0;
         word_cnt   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (dropped) begin
            overflow_q <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  overflow_q <= 1'b0;
                  word_cnt   <= '0;
                  if (tile_len == '0) begin
                     state <= DRAIN;
                  end else begin
                     len_q <= clamped_len;
                     state <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (data_in_valid) begin
                  word_cnt <= word_cnt + LEN_W'(1);
                  if (is_last) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sa_result_drain.md
# sa_result_drain

Receiving end of the spatial array's cell data stream. Captures the data_out / data_out_valid beats leaving the last sa_cell of a column. The cell has no backpressure, so the block counts beats into a result tile of programmable length and buffers them in a FIFO. It then presents the tile to the host side on a valid/ready stream with a last marker, an overflow flag and a completion pulse.

## Interface
- DATA_WIDTH, 16, width of one result word (FP16 from the cell)
- FIFO_DEPTH, 8, buffer entries; power of two, >= 2
- MAX_TILE_LEN, 256, largest tile in words; LEN_W = $clog2(MAX_TILE_LEN+1)

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, asynchronous and active-high
- start  input  1  one-cycle pulse; begins a tile; ignored while busy
- tile_len  input  LEN_W  words in the tile; sampled on accepted start
- data_in  input  DATA_WIDTH  result word from the cell's data_out
- data_in_valid  input  1  qualifies data_in (cell's data_out_valid)
- m_data  output  DATA_WIDTH  FIFO head word
- m_last  output  1  head word is the final word of the tile
- m_valid  output  1  FIFO not empty
- m_ready  input  1  host accepts the head word when m_valid && m_ready
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when the tile has fully left the block
- overflow  output  1  sticky; at least one word was dropped in the current tile
- fifo_count  output  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- States:
  - IDLE: waits for start.
  - COLLECT: counts incoming beats.
  - DRAIN: waits for the FIFO to empty.
- IDLE, start=1 with tile_len>0: latch len = min(tile_len, MAX_TILE_LEN), clear word counter and overflow, go to COLLECT.
- IDLE, start=1 with tile_len=0: go directly to DRAIN. Because the FIFO is empty, done pulses on the next cycle.
- COLLECT: every data_in_valid beat increments the counter. The beat is pushed with last = (counter == len-1). After the beat with counter == len-1, go to DRAIN.
- data_in_valid in IDLE or DRAIN: ignored. Nothing is pushed and nothing is counted.
- FIFO full with no pop in the same cycle: the beat is dropped, overflow is set, and the beat is still counted, so the tile always terminates. If the dropped beat was the last word, no m_last is ever presented.
- FIFO full with a pop in the same cycle: the push is accepted, so occupancy stays at FIFO_DEPTH.
- DRAIN: when the FIFO is empty (after the pop of the last word, or immediately), assert done for one cycle and go to IDLE.
- Pop: m_valid && m_ready removes the head. m_data and m_last are held stable while m_valid && !m_ready.
- Popping is allowed in every state. Words remaining from the previous tile are still delivered before the new tile's words.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. fifo_count is the registered occupancy.

## Timing
- Reset values: m_valid=0, m_last=0, m_data=0, busy=0, done=0, overflow=0, fifo_count=0; FIFO empty; state IDLE.
- Reset mid-tile drops all buffered words and the count with no done pulse.
- Start accepted at edge N: busy=1 after edge N. The first beat can be captured at edge N+1.
- Push at edge N: m_valid=1, with the word on m_data, after edge N. Latency is 1 cycle, show-ahead head.
- The last word is popped at edge N: done=1 during cycle N+1, busy=0 after edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- overflow changes only on a dropped beat (set) or an accepted start (clear).

## Structure
- sa_pkg holds:
  - typedef enum logic [1:0] drain_state_t {IDLE, COLLECT, DRAIN}
  - default DATA_WIDTH
  - shared sa_cell constants
- Sub-module sa_sync_fifo (WIDTH = DATA_WIDTH+1, carrying the last bit; DEPTH = FIFO_DEPTH):
  - push/pop/full/empty/count
  - async active-high reset
  - simultaneous push and pop when full is legal
- Top level holds the FSM, the word counter and the overflow flag.

## Test plan
- Reset, then start with tile_len=4 and beats 3C00, 4000, 4200, 4400, m_ready=1 -> words emerge in order one cycle after each push; m_last only on 4400; done pulses one cycle after the 4400 pop; overflow=0.
- tile_len=12 and 12 consecutive beats with m_ready=0 -> fifo_count saturates at 8; overflow=1; the last 4 words are dropped; after m_ready=1, 8 words drain with no m_last and done pulses; the next start clears overflow.
- FIFO full with m_ready=1 and a beat arriving -> push and pop in the same cycle, count stays at 8, no overflow.
- start with tile_len=0 -> busy for 1 cycle, then done; m_valid never asserts. data_in_valid in IDLE -> ignored.
- start asserted while busy -> ignored. Reset asserted mid-COLLECT with 3 words buffered -> all outputs return to reset values asynchronously, and no done pulse.
